// File: rtl/prng_rewind.sv
// prng_rewind
// Steps a minimal-standard (Park-Miller, a=16807, m=2^31-1) generator back
// by one state. It multiplies the operand by the modular inverse of 16807
// (1407677000) with an MSB-first double-and-add over the 31 constant bits.
// Every partial result is reduced with the Mersenne identity 2^31 == 1 (mod m).
//
// Ports
//   clk       : single clock, all state updates on the rising edge
//   rst       : asynchronous, active-low reset
//   rand_in   : generator output to rewind, captured when start is accepted
//   start     : request, 4-phase handshake with done
//   done      : result valid (registered)
//   err       : operand was 0 or >= 2^31-1 (registered, valid with done)
//   seed_out  : predecessor state, bit 31 always 0 (registered)
//   cont      : (PRNG_REWIND_CONT_EN only) chain another rewind step
//
// Optional feature macro: PRNG_REWIND_CONT_EN
//   When defined, holding cont high in DONE (with err=0) feeds seed_out back
//   as the next operand, so one handshake can walk the sequence backwards
//   several steps.

module prng_rewind (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rand_in,
  input  logic        start,
  output logic        done,
  output logic        err,
  output logic [31:0] seed_out
`ifdef PRNG_REWIND_CONT_EN
  ,
  input  logic        cont
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [30:0] MODULUS   = 31'h7FFF_FFFF;
  localparam logic [30:0] INV_A     = 31'd1407677000;
  localparam logic [4:0]  TOP_BIT   = 5'd30;
  localparam logic [4:0]  LATCH_CNT = 5'd31;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [30:0] r_x;
  logic [30:0] r_acc;
  logic [30:0] r_seed;
  logic [4:0]  r_cnt;
  logic        r_bad;
  logic        r_done;
  logic        r_err;

  logic        w_operand_bad;
  logic        w_accept;
  logic        w_step;
  logic        w_latch;
  logic        w_release;
  logic        w_chain;
  logic [4:0]  w_bit_idx;
  logic [30:0] w_dbl;
  logic [31:0] w_sum;
  logic [30:0] w_red;
  logic [30:0] w_acc_nxt;

  assign done     = r_done;
  assign err      = r_err;
  assign seed_out = {1'b0, r_seed};

  // Operands of 0 or m and above have no predecessor in the generator cycle.
  assign w_operand_bad = (rand_in == 32'd0) || (rand_in >= 32'h7FFF_FFFF);

`ifdef PRNG_REWIND_CONT_EN
  // Chaining only continues from a good result; a flagged error ends the walk.
  assign w_chain = (r_state == DONE) && cont && !r_err;
`else
  assign w_chain = 1'b0;
`endif

  // One double-and-add step. Doubling modulo a Mersenne prime is a 31-bit
  // rotate-left. The sum of two residues is below 2m, so a single end-around
  // carry brings it back below m+1, and the lone value m is folded to 0.
  always_comb begin
    w_bit_idx = TOP_BIT - r_cnt;
    w_dbl     = {r_acc[29:0], r_acc[30]};
    if (w_dbl == MODULUS) begin
      w_dbl = '0;
    end
    w_sum = {1'b0, w_dbl} + {1'b0, r_x};
    w_red = w_sum[30:0] + {30'd0, w_sum[31]};
    if (w_red == MODULUS) begin
      w_red = '0;
    end
    w_acc_nxt = INV_A[w_bit_idx] ? w_red : w_dbl;
  end

  // Next-state logic. RUN spends 31 cycles on arithmetic (r_cnt 0..30) and
  // one cycle latching the result, so done rises on the 32nd edge after
  // acceptance. A rejected operand enters RUN with the counter already at
  // the latch value, so done follows one edge after acceptance.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_latch     = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (r_cnt == LATCH_CNT) begin
          w_latch     = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_step = 1'b1;
        end
      end
      DONE: begin
        if (w_chain) begin
          w_state_nxt = RUN;
        end else if (!start) begin
          w_release   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and registered handshake outputs. seed_out is left untouched
  // when the handshake releases so the last result stays readable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x    <= '0;
      r_acc  <= '0;
      r_seed <= '0;
      r_cnt  <= '0;
      r_bad  <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_x   <= rand_in[30:0];
      r_acc <= '0;
      r_bad <= w_operand_bad;
      r_cnt <= w_operand_bad ? LATCH_CNT : 5'd0;
    end else if (w_chain) begin
      r_x    <= r_seed;
      r_acc  <= '0;
      r_bad  <= 1'b0;
      r_cnt  <= 5'd0;
      r_done <= 1'b0;
    end else if (w_step) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + 5'd1;
    end else if (w_latch) begin
      r_seed <= r_bad ? 31'd0 : r_acc;
      r_err  <= r_bad;
      r_done <= 1'b1;
    end else if (w_release) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end
  end

endmodule
